// File: rtl/avalon_pipeline_bridge.sv
// Avalon-MM register stage: 2-entry command FIFO between slave and master ports,
// registered read-data return path and a credit counter capping outstanding reads.
module avalon_pipeline_bridge #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [AW-1:0]     s_av_address_i,
  input  logic [DW/8-1:0]   s_av_byteenable_i,
  input  logic              s_av_read_i,
  input  logic              s_av_write_i,
  input  logic [DW-1:0]     s_av_writedata_i,
  output logic              s_av_waitrequest_o,
  output logic [DW-1:0]     s_av_readdata_o,
  output logic              s_av_readdatavalid_o,
  output logic [AW-1:0]     m_av_address_o,
  output logic [DW/8-1:0]   m_av_byteenable_o,
  output logic              m_av_read_o,
  output logic              m_av_write_o,
  output logic [DW-1:0]     m_av_writedata_o,
  output logic [7:0]        m_av_burstcount_o,
  input  logic              m_av_waitrequest_i,
  input  logic [DW-1:0]     m_av_readdata_i,
  input  logic              m_av_readdatavalid_i,
  output logic              resp_err_o
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam int EW = 1 + AW + BW + DW;

  // Entry layout: {we, address, byteenable, writedata}; r_e0 is always the head.
  logic [EW-1:0] r_e0;
  logic [EW-1:0] r_e1;
  logic [1:0]    r_count;
  logic [CW-1:0] r_pending;
  logic          r_rdv;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  logic          w_wait;
  logic          w_we;
  logic          w_push;
  logic          w_pop;
  logic          w_inc;
  logic          w_dec;
  logic          w_spurious;
  logic [EW-1:0] w_new;

  // Stall decision uses registered state only, so no path from m_av_waitrequest_i.
  assign w_wait     = (r_count == 2'd2) | (r_pending == CW'(MAX_PENDING));
  assign w_we       = s_av_write_i;
  assign w_push     = (s_av_read_i | s_av_write_i) & ~w_wait;
  assign w_pop      = (r_count != 2'd0) & ~m_av_waitrequest_i;
  assign w_new      = {w_we, s_av_address_i, s_av_byteenable_i, s_av_writedata_i};
  assign w_inc      = w_push & ~w_we;
  assign w_dec      = r_rdv & (r_pending != {CW{1'b0}});
  assign w_spurious = r_rdv & (r_pending == {CW{1'b0}});

  // Command FIFO; a simultaneous push and pop can only happen with one entry held.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_e0    <= {EW{1'b0}};
      r_e1    <= {EW{1'b0}};
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_e0 <= w_new;
          else                 r_e1 <= w_new;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_e0    <= r_e1;
          r_count <= r_count - 2'd1;
        end
        2'b11:   r_e0    <= w_new;
        default: r_count <= r_count;
      endcase
    end
  end

  // Credit counter, sticky spurious-response flag and registered response path.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_pending <= {CW{1'b0}};
      r_err     <= 1'b0;
      r_rdv     <= 1'b0;
      r_rdata   <= {DW{1'b0}};
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_pending <= r_pending + CW'(1);
        2'b01:   r_pending <= r_pending - CW'(1);
        default: r_pending <= r_pending;
      endcase
      r_err <= r_err | w_spurious;
      r_rdv <= m_av_readdatavalid_i;
      if (m_av_readdatavalid_i) r_rdata <= m_av_readdata_i;
    end
  end

  assign s_av_waitrequest_o   = w_wait;
  assign s_av_readdata_o      = r_rdata;
  assign s_av_readdatavalid_o = r_rdv;
  assign m_av_address_o       = r_e0[EW-2 -: AW];
  assign m_av_byteenable_o    = r_e0[DW +: BW];
  assign m_av_writedata_o     = r_e0[DW-1:0];
  assign m_av_read_o          = (r_count != 2'd0) & ~r_e0[EW-1];
  assign m_av_write_o         = (r_count != 2'd0) & r_e0[EW-1];
  assign m_av_burstcount_o    = 8'h01;
  assign resp_err_o           = r_err;

endmodule

// File: tb/tb_avalon_pipeline_bridge.sv
// Self-checking bench for avalon_pipeline_bridge: directed scenarios plus a randomized
// run, all checked against a queue-based transaction model.
module tb_avalon_pipeline_bridge;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;
  localparam int MAXP = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rd = 1'b0, wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [BW-1:0] be = '0;
  logic [DW-1:0] wdata = '0;
  logic mw = 1'b0, mrdv = 1'b0;
  logic [DW-1:0] mrdata = '0;
  logic s_wait, s_rdv, m_read, m_write, err;
  logic [DW-1:0] s_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;
  logic [7:0] m_burst;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
  } cmd_t;

  // Reference model state
  cmd_t mq[$];
  int   mpend = 0;
  bit   merr = 1'b0;
  bit   mrv = 1'b0;
  logic [DW-1:0] mrd = '0;

  avalon_pipeline_bridge #(.DW(DW), .AW(AW), .MAX_PENDING(MAXP)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .s_av_address_i(addr), .s_av_byteenable_i(be), .s_av_read_i(rd), .s_av_write_i(wr),
    .s_av_writedata_i(wdata), .s_av_waitrequest_o(s_wait), .s_av_readdata_o(s_rdata),
    .s_av_readdatavalid_o(s_rdv), .m_av_address_o(m_addr), .m_av_byteenable_o(m_be),
    .m_av_read_o(m_read), .m_av_write_o(m_write), .m_av_writedata_o(m_wdata),
    .m_av_burstcount_o(m_burst), .m_av_waitrequest_i(mw), .m_av_readdata_i(mrdata),
    .m_av_readdatavalid_i(mrdv), .resp_err_o(err)
  );

  always #5 clk = ~clk;

  function automatic bit exp_wait();
    return (mq.size() == 2) || (mpend == MAXP);
  endfunction

  task automatic reset_model();
    mq.delete();
    mpend = 0;
    merr  = 1'b0;
    mrv   = 1'b0;
    mrd   = '0;
  endtask

  // Apply the current inputs to the model, then clock and settle.
  task automatic advance();
    bit   acc;
    cmd_t c;
    acc  = (rd || wr) && !exp_wait();
    c.we = wr; c.a = addr; c.be = be; c.d = wdata;
    if (mq.size() > 0 && !mw) void'(mq.pop_front());
    if (acc) mq.push_back(c);
    if (mrv) begin
      if (mpend == 0) merr = 1'b1;
      else            mpend--;
    end
    if (acc && !wr) mpend++;
    mrv = mrdv;
    if (mrdv) mrd = mrdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd = 1'b0; wr = 1'b0; mrdv = 1'b0; mw = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({s_wait, s_rdv, m_read, m_write, err, s_rdata, m_addr, m_wdata, m_be} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %b/%b/%b/%b/%b %h %h %h %h expected all zero",
               s_wait, s_rdv, m_read, m_write, err, s_rdata, m_addr, m_wdata, m_be);
    end
    n_vec++;
    if (m_burst !== 8'h01) begin
      n_err++; $display("FAIL burstcount: got %h expected 01", m_burst);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_write();
    wr = 1'b1; addr = 32'h100; wdata = 32'hDEADBEEF; be = 4'hF;
    n_vec++;
    if (s_wait !== 1'b0) begin n_err++; $display("FAIL wr_wait: got %b expected 0", s_wait); end
    advance();
    wr = 1'b0;
    n_vec++;
    if ({m_write, m_read, m_addr, m_wdata, m_be} !== {1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF}) begin
      n_err++;
      $display("FAIL wr_issue: got w%b r%b %h %h %h expected w1 r0 00000100 deadbeef f",
               m_write, m_read, m_addr, m_wdata, m_be);
    end
    advance();
    n_vec++;
    if ({m_write, s_wait} !== 2'b00) begin
      n_err++; $display("FAIL wr_drain: got w%b wait%b expected 0 0", m_write, s_wait);
    end
  endtask

  task automatic test_read_latency();
    rd = 1'b1; addr = 32'h200; be = 4'hF;
    advance();
    rd = 1'b0;
    n_vec++;
    if ({m_read, m_addr} !== {1'b1, 32'h200}) begin
      n_err++; $display("FAIL rd_issue: got r%b %h expected r1 00000200", m_read, m_addr);
    end
    advance(); advance(); advance();
    mrdv = 1'b1; mrdata = 32'h12345678;
    n_vec++;
    if (s_rdv !== 1'b0) begin n_err++; $display("FAIL rd_early: got %b expected 0", s_rdv); end
    advance();
    mrdv = 1'b0; mrdata = 32'h0BAD0BAD;
    n_vec++;
    if ({s_rdv, s_rdata} !== {1'b1, 32'h12345678}) begin
      n_err++; $display("FAIL rd_data: got v%b %h expected v1 12345678", s_rdv, s_rdata);
    end
    advance();
    n_vec++;
    if ({s_rdv, s_rdata, err} !== {1'b0, 32'h12345678, 1'b0} || mpend != 0) begin
      n_err++; $display("FAIL rd_hold: got v%b %h err%b expected v0 12345678 err0", s_rdv, s_rdata, err);
    end
  endtask

  task automatic test_credit_limit();
    int acc = 0;
    rd = 1'b1; addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (s_wait !== exp_wait()) begin
        n_err++; $display("FAIL credit_wait%0d: got %b expected %b", i, s_wait, exp_wait());
      end
      if (!exp_wait()) begin acc++; end
      advance();
      if (acc > i) addr = addr + 32'h4;
    end
    n_vec++;
    if (acc != 4 || s_wait !== 1'b1) begin
      n_err++; $display("FAIL credit_accepts: got %0d wait%b expected 4 wait1", acc, s_wait);
    end
    mrdv = 1'b1; mrdata = 32'hA0;
    advance();
    mrdv = 1'b0;
    n_vec++;
    if ({s_rdv, s_wait} !== 2'b11) begin
      n_err++; $display("FAIL credit_fwd: got v%b wait%b expected v1 wait1", s_rdv, s_wait);
    end
    advance();
    n_vec++;
    if (s_wait !== 1'b0) begin n_err++; $display("FAIL credit_release: got %b expected 0", s_wait); end
    advance();
    rd = 1'b0;
    n_vec++;
    if (s_wait !== 1'b1) begin n_err++; $display("FAIL credit_refill: got %b expected 1", s_wait); end
    for (int i = 0; i < 4; i++) begin mrdv = 1'b1; mrdata = 32'hB0 + i; advance(); end
    mrdv = 1'b0; advance(); advance();
    n_vec++;
    if ({s_wait, err} !== 2'b00 || mpend != 0) begin
      n_err++; $display("FAIL credit_drain: got wait%b err%b expected 0 0", s_wait, err);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] dv[3];
    logic [DW-1:0] seen[$];
    int acc = 0;
    dv[0] = 32'h11110000; dv[1] = 32'h22220000; dv[2] = 32'h33330000;
    mw = 1'b1; wr = 1'b1; be = 4'h3;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h400 + acc; wdata = dv[acc];
      n_vec++;
      if (s_wait !== exp_wait()) begin
        n_err++; $display("FAIL bp_wait%0d: got %b expected %b", i, s_wait, exp_wait());
      end
      if (!exp_wait()) acc++;
      advance();
    end
    n_vec++;
    if (acc != 2 || s_wait !== 1'b1 || m_wdata !== dv[0]) begin
      n_err++; $display("FAIL bp_full: got %0d wait%b head %h expected 2 wait1 %h", acc, s_wait, m_wdata, dv[0]);
    end
    mw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr = 32'h400 + acc; wdata = dv[acc < 3 ? acc : 2];
      if (m_write) seen.push_back(m_wdata);
      if (!exp_wait() && acc < 3) acc++;
      if (acc == 3 && wr && exp_wait() == 1'b0) begin advance(); wr = 1'b0; end
      else advance();
    end
    wr = 1'b0;
    n_vec++;
    if (seen.size() != 3 || seen[0] !== dv[0] || seen[1] !== dv[1] || seen[2] !== dv[2]) begin
      n_err++; $display("FAIL bp_order: got %0d writes expected 3 in order", seen.size());
    end
  endtask

  task automatic test_simultaneous();
    int acc = 0;
    idle_inputs();
    rd = 1'b1; addr = 32'h500; advance(); advance();
    rd = 1'b0; advance();
    mrdv = 1'b1; mrdata = 32'hC0; advance();
    mrdv = 1'b0; rd = 1'b1; addr = 32'h504;
    n_vec++;
    if ({s_rdv, s_wait} !== 2'b10) begin
      n_err++; $display("FAIL simul_cond: got v%b wait%b expected v1 wait0", s_rdv, s_wait);
    end
    advance();
    for (int i = 0; i < 4; i++) begin
      if (!s_wait) acc++;
      advance();
    end
    rd = 1'b0;
    n_vec++;
    if (acc != 2 || mpend != MAXP) begin
      n_err++; $display("FAIL simul_pending: got %0d extra accepts expected 2", acc);
    end
    for (int i = 0; i < 4; i++) begin mrdv = 1'b1; advance(); end
    mrdv = 1'b0; advance(); advance();
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 3);
      rd = (k == 1) || (k == 3); wr = (k >= 2);
      addr = $urandom; be = 4'($urandom); wdata = $urandom;
      mw = ($urandom_range(0, 3) == 0);
      mrdv = ((mpend - int'(mrv)) > 0) && ($urandom_range(0, 1) == 1);
      mrdata = $urandom;
      n_vec++;
      if (s_wait !== exp_wait()) begin
        n_err++; $display("FAIL rnd_wait@%0d: got %b expected %b", i, s_wait, exp_wait());
      end
      n_vec++;
      if (m_read !== (mq.size() > 0 && !mq[0].we) || m_write !== (mq.size() > 0 && mq[0].we)) begin
        n_err++; $display("FAIL rnd_cmd@%0d: got r%b w%b expected size %0d", i, m_read, m_write, mq.size());
      end
      if (mq.size() > 0) begin
        n_vec++;
        if ({m_addr, m_be, m_wdata} !== {mq[0].a, mq[0].be, mq[0].d}) begin
          n_err++; $display("FAIL rnd_head@%0d: got %h %h %h expected %h %h %h",
                            i, m_addr, m_be, m_wdata, mq[0].a, mq[0].be, mq[0].d);
        end
      end
      n_vec++;
      if ({s_rdv, s_rdata, err} !== {mrv, mrd, merr}) begin
        n_err++; $display("FAIL rnd_resp@%0d: got v%b %h e%b expected v%b %h e%b",
                          i, s_rdv, s_rdata, err, mrv, mrd, merr);
      end
      advance();
    end
    idle_inputs();
    for (int i = 0; i < 40 && mpend > 0; i++) begin
      mrdv = (mpend - int'(mrv)) > 0;
      advance();
    end
    mrdv = 1'b0; advance(); advance();
    n_vec++;
    if (mpend != 0 || err !== 1'b0 || s_wait !== 1'b0) begin
      n_err++; $display("FAIL rnd_drain: got err%b wait%b pend %0d expected 0 0 0", err, s_wait, mpend);
    end
  endtask

  task automatic test_error_reset();
    idle_inputs();
    mrdv = 1'b1; mrdata = 32'hCAFE0001;
    advance();
    mrdv = 1'b0;
    n_vec++;
    if ({s_rdv, s_rdata, err} !== {1'b1, 32'hCAFE0001, 1'b0}) begin
      n_err++; $display("FAIL err_fwd: got v%b %h e%b expected v1 cafe0001 e0", s_rdv, s_rdata, err);
    end
    advance(); advance(); advance();
    n_vec++;
    if (err !== 1'b1 || merr != 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", err); end
    mw = 1'b1; wr = 1'b1; addr = 32'h600; wdata = 32'h5A5A5A5A; be = 4'hF;
    advance();
    rd = 1'b1; wr = 1'b0; mrdv = 1'b1; mrdata = 32'h77;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_wait, s_rdv, m_read, m_write, err, s_rdata, m_addr, m_wdata, m_be} !== '0) begin
      n_err++; $display("FAIL async_reset: got %b/%b/%b/%b/%b %h %h expected all zero",
                        s_wait, s_rdv, m_read, m_write, err, m_addr, m_wdata);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_model();
    mrdv = 1'b1; mrdata = 32'h99;
    advance();
    mrdv = 1'b0;
    advance();
    n_vec++;
    if ({err, s_rdata} !== {1'b1, 32'h99}) begin
      n_err++; $display("FAIL post_reset_err: got e%b %h expected e1 00000099", err, s_rdata);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_read_latency();
    test_credit_limit();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_error_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/avalon_pipeline_bridge.md
Name: avalon_pipeline_bridge

Overview:
- Avalon-MM register stage placed directly downstream of the Wishbone-to-Avalon bridge.
- Accepts single-beat pipelined read/write commands on an Avalon slave port and buffers them in a 2-entry command FIFO.
- Re-issues the commands on an Avalon master port and returns read data one cycle later through a registered response path.
- Caps outstanding reads with a credit counter. There is no combinational path from m_av_waitrequest_i to s_av_waitrequest_o, which breaks timing between interconnect and slave.

Parameters:
- DW, 32, data width (multiple of 8)
- AW, 32, address width
- MAX_PENDING, 4, maximum reads accepted but not yet returned on s_av_readdatavalid_o (1..15)

Ports:
- wb_clk_i  in  1  clock, all logic rising-edge
- wb_rst_ni  in  1  reset, asynchronous assert, active-low
- s_av_address_i  in  AW  slave command address
- s_av_byteenable_i  in  DW/8  slave byte enables
- s_av_read_i  in  1  read request
- s_av_write_i  in  1  write request
- s_av_writedata_i  in  DW  write data
- s_av_waitrequest_o  out  1  command not accepted this cycle
- s_av_readdata_o  out  DW  returned read data
- s_av_readdatavalid_o  out  1  s_av_readdata_o valid
- m_av_address_o  out  AW  head-of-FIFO address
- m_av_byteenable_o  out  DW/8  head byte enables
- m_av_read_o  out  1  head is a read
- m_av_write_o  out  1  head is a write
- m_av_writedata_o  out  DW  head write data
- m_av_burstcount_o  out  8  constant 8'h1
- m_av_waitrequest_i  in  1  downstream stall
- m_av_readdata_i  in  DW  downstream read data
- m_av_readdatavalid_i  in  1  downstream read data valid
- resp_err_o  out  1  sticky: response arrived with zero reads pending

Behaviour:
- Reset state (wb_rst_ni low, asynchronous):
  - FIFO empty, credit counter 0.
  - All m_av_read_o, m_av_write_o, s_av_readdatavalid_o and resp_err_o are 0; s_av_readdata_o and m_av_* data/address are 0.
  - s_av_waitrequest_o = 0.
- Reset mid-operation: buffered commands and in-flight reads are discarded. Responses arriving after reset release with zero pending set resp_err_o.
- Command accept: accept = (s_av_read_i | s_av_write_i) & !s_av_waitrequest_o.
  - Read and write both high in the same cycle is illegal; the block treats it as a write.
- s_av_waitrequest_o = (fifo_count == 2) | (pending == MAX_PENDING).
  - Both terms are registered state only.
  - Writes also stall at the credit limit.
  - s_av_waitrequest_o is 0 whenever neither of its terms holds, regardless of whether a request is present.
- FIFO:
  - 2 entries of {we, address, byteenable, writedata}.
  - Head drives the m_av_* outputs; m_av_read_o = !empty & !we and m_av_write_o = !empty & we.
  - Pop on !empty & !m_av_waitrequest_i.
  - Push and pop in the same cycle leaves the count unchanged.
  - A push while full is impossible, since waitrequest blocks it.
  - Sustained throughput is 1 command/cycle when the downstream never stalls; a full FIFO with a pop this cycle still reports waitrequest this cycle.
- Latency:
  - Accepted command appears on m_av_* the cycle after accept at the earliest.
  - Read data: s_av_readdatavalid_o <= m_av_readdatavalid_i and s_av_readdata_o <= m_av_readdata_i, i.e. one register. s_av_readdata_o is updated only when m_av_readdatavalid_i = 1 and holds otherwise.
- Credit counter:
  - Width $clog2(MAX_PENDING+1).
  - +1 on an accepted read; -1 on s_av_readdatavalid_o; both in the same cycle leaves it unchanged.
  - Never wraps. A decrement at 0 is suppressed and sets resp_err_o instead.
  - The spurious response is still forwarded to the slave side.
- resp_err_o clears only on reset.
- Ordering: commands leave in acceptance order; responses are returned in downstream order. The block does not reorder.

Test Plan:
- Write, no stall: write addr 0x100, data 0xDEADBEEF, be 0xF -> m_av_write_o high the next cycle with the same fields for 1 cycle; FIFO empties; waitrequest stays 0.
- Read latency: read 0x200; downstream returns 0x12345678 three cycles after issue -> s_av_readdatavalid_o one cycle after m_av_readdatavalid_i with data 0x12345678; pending goes 0→1→0.
- Credit limit: 5 back-to-back reads with MAX_PENDING = 4 and no responses -> 4 accepted, s_av_waitrequest_o high on the 5th. After one response is forwarded, the 5th is accepted the following cycle.
- Backpressure: hold m_av_waitrequest_i high, issue 3 writes -> 2 accepted and waitrequest high. Release the stall -> writes emerge in order, one per cycle, then the 3rd is accepted.
- Simultaneous events: with pending = 2, accept a read in the same cycle as s_av_readdatavalid_o -> pending stays 2.
- Error and reset: readdatavalid with pending = 0 -> resp_err_o = 1 and held. Assert wb_rst_ni low asynchronously mid-burst -> all outputs 0 immediately; resp_err_o cleared.
